// File: rtl/ascon_pkg.sv
// Shared definitions for the SPI register bank: FSM states, command byte layout and
// the burst-address helper.
package ascon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        SKIP
    } spi_state_e;

    localparam int unsigned CMD_W        = 8;
    localparam int unsigned CMD_RW_BIT   = 7;
    localparam int unsigned CMD_ADDR_MSB = 6;
    localparam int unsigned ADDR_W       = CMD_ADDR_MSB + 1;

    // Next burst address; anything at or past the last register wraps to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                   input int unsigned n);
        return ((32'(a) + 32'd1) >= n) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/spi_edge_det.sv
// SPI clock edge detector: registered copy of the synchronised sck plus
// single-cycle rise/fall strobes.
module spi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    output logic rise,
    output logic fall
);

    logic sck_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev <= 1'b0;
        end else begin
            sck_prev <= sck;
        end
    end

    assign rise = sck & ~sck_prev;
    assign fall = ~sck & sck_prev;

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 target exposing NUM_REGS registers, shared with the accelerator through a
// writeback port. Define SPI_AUTOINC_EN for burst frames with auto-incrementing address.
module spi_regbank #(
    parameter int unsigned NUM_REGS = 3,
    parameter int unsigned REG_W    = 128,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sck_sync,
    input  logic                      csb_sync,
    input  logic                      mosi_sync,
    output logic                      miso,
    input  logic                      wrback_en,
    input  logic [SEL_W-1:0]          wrback_sel,
    input  logic [REG_W-1:0]          wrback_val,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic                      spi_busy,
    output logic                      wr_collide
);

    import ascon_pkg::*;

    localparam int unsigned CNT_W = $clog2(REG_W);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-2:0]  cmd_q, cmd_d;
    logic [REG_W-1:0]  sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              miso_q, miso_d;
    logic              busy_q;
    logic              collide_q;
    logic [REG_W-1:0]  regs_q [NUM_REGS];

    logic              rise, fall;
    logic [CMD_W-1:0]  cmd_full;
    logic [ADDR_W-1:0] load_addr;
    logic [REG_W-1:0]  snap;
    logic [REG_W-1:0]  commit_val;
    logic              commit;

    spi_edge_det u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .sck  (sck_sync),
        .rise (rise),
        .fall (fall)
    );

    assign cmd_full   = {cmd_q, mosi_sync};
    assign commit_val = {sr_q[REG_W-2:0], mosi_sync};

    // Snapshot source: the addressed register, or zero for an invalid address.
    always_comb begin
        load_addr = cmd_full[CMD_ADDR_MSB:0];
`ifdef SPI_AUTOINC_EN
        if (state_q == DATA) begin
            load_addr = wrap_inc(addr_q, NUM_REGS);
        end
`endif
        snap = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (load_addr == ADDR_W'(i)) begin
                snap = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        miso_d  = miso_q;
        commit  = 1'b0;
        if (csb_sync) begin
            state_d = IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: begin
                    if (rise) begin
                        cmd_d = cmd_full[CMD_W-2:0];
                        if (cnt_q == CNT_W'(CMD_W - 1)) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            wr_d    = cmd_full[CMD_RW_BIT];
                            addr_d  = cmd_full[CMD_ADDR_MSB:0];
                            sr_d    = snap;
                            miso_d  = ~cmd_full[CMD_RW_BIT] & snap[REG_W-1];
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (rise) begin
                        sr_d = commit_val;
                        if (cnt_q == CNT_W'(REG_W - 1)) begin
                            cnt_d  = '0;
                            commit = wr_q && (32'(addr_q) < NUM_REGS);
`ifdef SPI_AUTOINC_EN
                            addr_d = load_addr;
                            sr_d   = snap;
                            miso_d = ~wr_q & snap[REG_W-1];
`else
                            state_d = SKIP;
                            miso_d  = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (fall) begin
                        // sr MSB is the bit the host samples on the coming rise
                        miso_d = ~wr_q & sr_q[REG_W-1];
                    end
                end
                SKIP: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
            collide_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            miso_q  <= miso_d;
            busy_q  <= ~csb_sync;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (commit && (32'(addr_q) == i)) begin
                    regs_q[i] <= commit_val;
                end else if (wrback_en && (32'(wrback_sel) == i)) begin
                    regs_q[i] <= wrback_val;
                end
            end
            if (commit && wrback_en && (32'(wrback_sel) == 32'(addr_q))) begin
                collide_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*REG_W +: REG_W] = regs_q[g];
    end

    assign miso       = miso_q;
    assign spi_busy   = busy_q;
    assign wr_collide = collide_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank (NUM_REGS=3, REG_W=16, sck = clk/8); honours
// SPI_AUTOINC_EN for the burst expectations.
module tb_spi_regbank;

    localparam int unsigned NUM_REGS = 3;
    localparam int unsigned REG_W    = 16;
    localparam int unsigned SEL_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      sck;
    logic                      csb;
    logic                      mosi;
    logic                      miso;
    logic                      wb_en;
    logic [SEL_W-1:0]          wb_sel;
    logic [REG_W-1:0]          wb_val;
    logic [NUM_REGS*REG_W-1:0] regs_flat;
    logic                      busy;
    logic                      collide;

    int         checks = 0;
    int         fails  = 0;
    logic [15:0] model [NUM_REGS];
    logic        model_collide;
    bit          autoinc;

    always #5 clk = ~clk;

    spi_regbank #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .SEL_W    (SEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sck_sync   (sck),
        .csb_sync   (csb),
        .mosi_sync  (mosi),
        .miso       (miso),
        .wrback_en  (wb_en),
        .wrback_sel (wb_sel),
        .wrback_val (wb_val),
        .regs_flat  (regs_flat),
        .spi_busy   (busy),
        .wr_collide (collide)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] reg_of(input int i);
        return regs_flat[i*16 +: 16];
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            check($sformatf("%s reg%0d", tag, i), 32'(reg_of(i)), 32'(model[i]));
        end
        check($sformatf("%s wr_collide", tag), 32'(collide), 32'(model_collide));
    endtask

    // One SPI bit: low half then rising edge; returns one clk after the rise is seen.
    task automatic spi_bit(input logic b, input logic wb, output logic samp);
        repeat (3) @(negedge clk);
        sck  = 1'b0;
        mosi = b;
        repeat (4) @(negedge clk);
        samp = miso;
        sck  = 1'b1;
        if (wb) wb_en = 1'b1;
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] data, input int nbits,
                             input int wb_bit, output logic [63:0] rx);
        logic s;
        rx  = '0;
        csb = 1'b0;
        repeat (2) @(negedge clk);
        check("spi_busy in frame", 32'(busy), 32'd1);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], 1'b0, s);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(data[nbits-1-i], i == wb_bit, s);
            rx = {rx[62:0], s};
        end
    endtask

    task automatic end_frame();
        repeat (3) @(negedge clk);
        sck = 1'b0;
        repeat (2) @(negedge clk);
        csb = 1'b1;
        @(negedge clk);
        check("miso after csb high", 32'(miso), 32'd0);
        check("spi_busy after csb high", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Model of a completed write frame: each full word lands at addr, bursting if enabled.
    task automatic model_write(input int addr, input logic [63:0] data, input int nwords);
        int a = addr;
        for (int w = 0; w < nwords; w++) begin
            if (w > 0 && !autoinc) break;
            if (a < int'(NUM_REGS)) model[a] = data[(nwords-1-w)*16 +: 16];
            a = (a + 1 >= int'(NUM_REGS)) ? 0 : a + 1;
        end
    endtask

    task automatic writeback(input int sel, input logic [15:0] val);
        wb_sel = SEL_W'(sel);
        wb_val = val;
        wb_en  = 1'b1;
        @(negedge clk);
        wb_en = 1'b0;
        if (sel < int'(NUM_REGS)) model[sel] = val;
    endtask

    initial begin
        logic [63:0] rx;
        int          op, a;
        logic [15:0] d;
`ifdef SPI_AUTOINC_EN
        autoinc = 1'b1;
`else
        autoinc = 1'b0;
`endif
        rst = 1'b1; sck = 1'b0; csb = 1'b1; mosi = 1'b0;
        wb_en = 1'b0; wb_sel = '0; wb_val = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        model_collide = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_regs("reset");
        check("reset miso", 32'(miso), 32'd0);
        check("reset spi_busy", 32'(busy), 32'd0);

        // Single write to reg1
        spi_frame(8'h81, 64'hBEEF, 16, -1, rx);
        model_write(1, 64'hBEEF, 1);
        check_regs("write 0x81");
        end_frame();

        // Read back reg1
        spi_frame(8'h01, 64'h0, 16, -1, rx);
        check("read 0x01 data", 32'(rx[15:0]), 32'(model[1]));
        end_frame();

        // Read aborted before the first data bit: miso must drop the cycle after csb high
        spi_frame(8'h01, 64'h0, 0, -1, rx);
        repeat (3) @(negedge clk);
        sck = 1'b0;
        repeat (3) @(negedge clk);
        check("aborted read msb", 32'(miso), 32'(model[1][15]));
        csb = 1'b1;
        @(negedge clk);
        check("aborted read miso cleared", 32'(miso), 32'd0);
        repeat (2) @(negedge clk);

        // Partial write discarded
        spi_frame(8'h82, 64'h12, 8, -1, rx);
        end_frame();
        check_regs("partial write");

        // Collision: writeback to the register being committed
        wb_sel = 2'd1;
        wb_val = 16'hAAAA;
        spi_frame(8'h81, 64'h5555, 16, 15, rx);
        model_write(1, 64'h5555, 1);
        model_collide = 1'b1;
        check_regs("collision");
        end_frame();

        // Burst write
        spi_frame(8'h82, 64'h0001_0002, 32, -1, rx);
        model_write(2, 64'h0001_0002, 2);
        end_frame();
        check_regs("burst");

        // Commit and writeback to different registers on the same edge
        wb_sel = 2'd2;
        wb_val = 16'h2468;
        spi_frame(8'h80, 64'h1357, 16, 15, rx);
        model_write(0, 64'h1357, 1);
        model[2] = 16'h2468;
        check_regs("commit+writeback");
        end_frame();

        // Invalid address
        spi_frame(8'h85, 64'hFFFF, 16, -1, rx);
        end_frame();
        check_regs("invalid write");
        spi_frame(8'h05, 64'h0, 16, -1, rx);
        check("invalid read data", 32'(rx[15:0]), 32'd0);
        end_frame();

        // Randomised traffic
        for (int n = 0; n < 14; n++) begin
            op = int'($urandom_range(0, 2));
            a  = int'($urandom_range(0, 4));
            d  = 16'($urandom);
            if (op == 0) begin
                spi_frame({1'b1, 7'(a)}, 64'(d), 16, -1, rx);
                model_write(a, 64'(d), 1);
                end_frame();
                check_regs($sformatf("rand write a=%0d", a));
            end else if (op == 1) begin
                spi_frame({1'b0, 7'(a)}, 64'h0, 16, -1, rx);
                check($sformatf("rand read a=%0d", a), 32'(rx[15:0]),
                      (a < int'(NUM_REGS)) ? 32'(model[a]) : 32'd0);
                end_frame();
            end else begin
                writeback(a % 4, d);
                check_regs($sformatf("rand writeback sel=%0d", a % 4));
            end
        end

        // Reset clears everything including the sticky collision flag
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) model[i] = '0;
        model_collide = 1'b0;
        check_regs("second reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
